// File: rtl/axis_s2mm_rr_arbiter_if.sv
// Stream and dual FWFT FIFO bundle for axis_s2mm_rr_arbiter.
// The master modport is the arbiter side. The slave modport is the FIFO/DMA side.
interface axis_s2mm_rr_arbiter_if #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_CNT_WIDTH     = 12
);
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   FIFO0_DATA;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   FIFO1_DATA;
  logic [C_FIFO_CNT_WIDTH-1:0]       FIFO0_RD_COUNT;
  logic [C_FIFO_CNT_WIDTH-1:0]       FIFO1_RD_COUNT;
  logic                              FIFO0_RD_EN;
  logic                              FIFO1_RD_EN;
  logic                              M_AXIS_TVALID;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
  logic                              M_AXIS_TLAST;
  logic                              M_AXIS_TREADY;

  modport master (
    input  FIFO0_DATA, FIFO1_DATA, FIFO0_RD_COUNT, FIFO1_RD_COUNT, M_AXIS_TREADY,
    output FIFO0_RD_EN, FIFO1_RD_EN, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
  );

  modport slave (
    output FIFO0_DATA, FIFO1_DATA, FIFO0_RD_COUNT, FIFO1_RD_COUNT, M_AXIS_TREADY,
    input  FIFO0_RD_EN, FIFO1_RD_EN, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_s2mm_rr_arbiter.sv
// Round-robin packet arbiter: two FWFT FIFOs onto one AXIS master. A packet is granted one ARB cycle after a full packet is buffered.
// TREADY stalls the packet without ever dropping TVALID. Defining S2MM_ARB_HEADER_EN prefixes each packet with a {ch, count} header beat.
module axis_s2mm_rr_arbiter #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_PKT_WORDS          = 1024,
  parameter int C_FIFO_CNT_WIDTH     = 12
) (
  input  logic                          M_AXIS_ACLK,
  input  logic                          M_AXIS_ARESETN,
  input  logic                          ENABLE,
  axis_s2mm_rr_arbiter_if.master        bus,
  output logic                          CH_ID,
  output logic [31:0]                   PKT_CNT0,
  output logic [31:0]                   PKT_CNT1
);

  localparam int BW = (C_PKT_WORDS > 2) ? $clog2(C_PKT_WORDS) : 1;
  localparam logic [BW-1:0] PRE_LAST = BW'(C_PKT_WORDS - 2);

`ifdef S2MM_ARB_HEADER_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARB = 2'd1, ST_SEND = 2'd2, ST_HDR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARB = 2'd1, ST_SEND = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          ch_id_q, ch_id_d;
  logic          prio_q, prio_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [31:0]   pkt_cnt1_q, pkt_cnt1_d;

  logic hs;
  logic elig0;
  logic elig1;
  logic grant;
  logic send_hs;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata;

  assign hs    = tvalid_q & bus.M_AXIS_TREADY;
  assign elig0 = 32'(bus.FIFO0_RD_COUNT) >= 32'(C_PKT_WORDS);
  assign elig1 = 32'(bus.FIFO1_RD_COUNT) >= 32'(C_PKT_WORDS);

  always_comb begin
    state_d    = state_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    ch_id_d    = ch_id_q;
    prio_d     = prio_q;
    beat_d     = beat_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    grant      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_ARB;
      end
      ST_ARB: begin
        // On a tie, prio_q names the channel that was not served last.
        grant = (elig0 && elig1) ? prio_q : elig1;
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (elig0 || elig1) begin
          ch_id_d  = grant;
          beat_d   = '0;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
`ifdef S2MM_ARB_HEADER_EN
          state_d  = ST_HDR;
`else
          state_d  = ST_SEND;
`endif
        end
      end
`ifdef S2MM_ARB_HEADER_EN
      ST_HDR: begin
        if (hs) state_d = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (hs) begin
          if (tlast_q) begin
            if (ch_id_q) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
            else         pkt_cnt0_d = pkt_cnt0_q + 32'd1;
            prio_d   = ~ch_id_q;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = ENABLE ? ST_ARB : ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            tlast_d = (beat_q == PRE_LAST);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      ch_id_q    <= 1'b0;
      prio_q     <= 1'b0;
      beat_q     <= '0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      ch_id_q    <= ch_id_d;
      prio_q     <= prio_d;
      beat_q     <= beat_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  always_comb begin
    tdata = ch_id_q ? bus.FIFO1_DATA : bus.FIFO0_DATA;
`ifdef S2MM_ARB_HEADER_EN
    // Header carries the pre-increment count of the granted channel.
    if (state_q == ST_HDR) begin
      tdata        = '0;
      tdata[31]    = ch_id_q;
      tdata[30:0]  = ch_id_q ? pkt_cnt1_q[30:0] : pkt_cnt0_q[30:0];
    end
`endif
  end

  // Only data beats pop. The header beat never does.
  assign send_hs = (state_q == ST_SEND) & hs;

  assign bus.FIFO0_RD_EN   = send_hs & ~ch_id_q;
  assign bus.FIFO1_RD_EN   = send_hs &  ch_id_q;
  assign bus.M_AXIS_TVALID = tvalid_q;
  assign bus.M_AXIS_TLAST  = tlast_q;
  assign bus.M_AXIS_TDATA  = tdata;
  assign bus.M_AXIS_TSTRB  = '1;
  assign CH_ID             = ch_id_q;
  assign PKT_CNT0          = pkt_cnt0_q;
  assign PKT_CNT1          = pkt_cnt1_q;

endmodule

// File: tb/tb_axis_s2mm_rr_arbiter.sv
// Directed bench for axis_s2mm_rr_arbiter: single packet, alternation, random TREADY, threshold, ENABLE drop, mid-packet reset.
module tb_axis_s2mm_rr_arbiter;
  localparam int DW  = 32;
  localparam int CW  = 12;
  localparam int PKT = 1024;
`ifdef S2MM_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          tready;
  logic          ch_id;
  logic [31:0]   pkt_cnt0, pkt_cnt1;
  logic [CW-1:0] cnt0, cnt1;
  logic [23:0]   pop0 = '0;
  logic [23:0]   pop1 = '0;

  int checks = 0;
  int failures = 0;
  int exp_base0 = 0, exp_base1 = 0;
  int exp_pkt0 = 0, exp_pkt1 = 0;

  int          r_wait, r_beats, r_cycles, r_lasts, r_last_beat, r_derr, r_vdrop, r_badpop, r_pops;
  logic        r_ch;
  logic [31:0] r_hdr, r_first;

  axis_s2mm_rr_arbiter_if #(.C_M_AXIS_TDATA_WIDTH(DW), .C_FIFO_CNT_WIDTH(CW)) bus ();

  axis_s2mm_rr_arbiter #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_PKT_WORDS(PKT),
    .C_FIFO_CNT_WIDTH(CW)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESETN(rst_n),
    .ENABLE(enable),
    .bus(bus),
    .CH_ID(ch_id),
    .PKT_CNT0(pkt_cnt0),
    .PKT_CNT1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  // FIFO model: head word is a channel tag plus the number of words popped so far.
  assign bus.FIFO0_DATA     = {8'hA0, pop0};
  assign bus.FIFO1_DATA     = {8'hB1, pop1};
  assign bus.FIFO0_RD_COUNT = cnt0;
  assign bus.FIFO1_RD_COUNT = cnt1;
  assign bus.M_AXIS_TREADY  = tready;

  always @(posedge clk) begin
    if (bus.FIFO0_RD_EN) pop0 <= pop0 + 24'd1;
    if (bus.FIFO1_RD_EN) pop1 <= pop1 + 24'd1;
  end

  // Collects one packet into r_* (no judgement here). Bounded by a cycle budget.
  task automatic collect(input bit rnd, input int drop_at, input int stop_at);
    int   guard;
    bit   started, done;
    logic hs, e0, e1;
    int   base, k;
    logic [31:0] expw;
    r_wait = 0; r_beats = 0; r_cycles = 0; r_lasts = 0; r_last_beat = -1;
    r_derr = 0; r_vdrop = 0; r_badpop = 0; r_pops = 0; r_ch = 1'b0;
    r_hdr = '0; r_first = '0;
    started = 0; done = 0; guard = 0;
    while (!done && guard < 4000) begin
      @(negedge clk);
      guard++;
      tready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      if (!started) begin
        if (bus.M_AXIS_TVALID) begin
          started = 1;
          r_ch = ch_id;
        end else begin
          r_wait++;
        end
      end
      if (started) begin
        r_cycles++;
        if (!bus.M_AXIS_TVALID) r_vdrop++;
        if (ch_id !== r_ch) r_derr++;
        hs = bus.M_AXIS_TVALID && tready;
        e0 = hs && !r_ch && (r_beats >= HDR);
        e1 = hs &&  r_ch && (r_beats >= HDR);
        if (bus.FIFO0_RD_EN !== e0 || bus.FIFO1_RD_EN !== e1) r_badpop++;
        if (bus.FIFO0_RD_EN || bus.FIFO1_RD_EN) r_pops++;
        if (hs) begin
          if (r_beats < HDR) begin
            r_hdr = bus.M_AXIS_TDATA;
          end else begin
            k    = r_beats - HDR;
            base = r_ch ? exp_base1 : exp_base0;
            expw = {(r_ch ? 8'hB1 : 8'hA0), 24'(base + k)};
            if (k == 0) r_first = bus.M_AXIS_TDATA;
            if (bus.M_AXIS_TDATA !== expw) r_derr++;
          end
          if (bus.M_AXIS_TLAST) begin
            r_lasts++;
            r_last_beat = r_beats;
            done = 1;
          end
          if (r_beats == drop_at) enable = 1'b0;
          if (r_beats == stop_at) done = 1;
          r_beats++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; tready = 1'b0; cnt0 = '0; cnt1 = '0;
    #2;
    checks++; if (bus.M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", bus.M_AXIS_TVALID); end
    checks++; if (bus.M_AXIS_TLAST !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", bus.M_AXIS_TLAST); end
    checks++; if ({bus.FIFO1_RD_EN, bus.FIFO0_RD_EN} !== 2'b00) begin failures++; $display("FAIL reset_rd_en: got %b want 00", {bus.FIFO1_RD_EN, bus.FIFO0_RD_EN}); end
    checks++; if (ch_id !== 1'b0) begin failures++; $display("FAIL reset_ch_id: got %b want 0", ch_id); end
    checks++; if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin failures++; $display("FAIL reset_pkt_cnt: got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (bus.M_AXIS_TDATA !== 32'hA000_0000) begin failures++; $display("FAIL reset_tdata: got %h want a0000000", bus.M_AXIS_TDATA); end
    checks++; if (bus.M_AXIS_TSTRB !== 4'hF) begin failures++; $display("FAIL reset_tstrb: got %h want f", bus.M_AXIS_TSTRB); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL idle_tvalid: got %b want 0", bus.M_AXIS_TVALID); end
  endtask

  task automatic test_single();
    cnt0 = 12'd1024; cnt1 = '0; enable = 1'b1;
    collect(0, -1, -1);
    cnt0 = '0;
    checks++; if (r_wait !== 1) begin failures++; $display("FAIL single_latency: got %0d want 1", r_wait); end
    checks++; if (r_beats !== PKT + HDR) begin failures++; $display("FAIL single_beats: got %0d want %0d", r_beats, PKT + HDR); end
    checks++; if (r_cycles !== PKT + HDR) begin failures++; $display("FAIL single_cycles: got %0d want %0d", r_cycles, PKT + HDR); end
    checks++; if (r_lasts !== 1 || r_last_beat !== PKT + HDR - 1) begin failures++; $display("FAIL single_tlast: got %0d at %0d want 1 at %0d", r_lasts, r_last_beat, PKT + HDR - 1); end
    checks++; if (r_derr !== 0) begin failures++; $display("FAIL single_data: got %0d errors want 0", r_derr); end
    checks++; if (r_badpop !== 0 || r_pops !== PKT) begin failures++; $display("FAIL single_pops: got %0d bad %0d pops want 0 bad %0d pops", r_badpop, r_pops, PKT); end
    checks++; if (r_ch !== 1'b0 || r_first !== 32'hA000_0000) begin failures++; $display("FAIL single_first: got ch%0d %h want ch0 a0000000", r_ch, r_first); end
    exp_base0 += PKT; exp_pkt0++;
    @(negedge clk);
    checks++; if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd0) begin failures++; $display("FAIL single_pkt_cnt: got %0d/%0d want 1/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (bus.M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL single_gap: got %b want 0", bus.M_AXIS_TVALID); end
  endtask

  task automatic test_alternate();
    logic exp_ch;
    cnt0 = 12'd2048; cnt1 = 12'd2048;
    for (int k = 0; k < 6; k++) begin
      exp_ch = (k % 2 == 0);
      collect(0, -1, -1);
      if (k == 5) cnt1 = '0;
      checks++; if (r_ch !== exp_ch) begin failures++; $display("FAIL alt_ch[%0d]: got %0d want %0d", k, r_ch, exp_ch); end
      checks++; if (r_wait !== ((k == 0) ? 0 : 1)) begin failures++; $display("FAIL alt_gap[%0d]: got %0d want %0d", k, r_wait, (k == 0) ? 0 : 1); end
      checks++; if (r_beats !== PKT + HDR || r_last_beat !== PKT + HDR - 1) begin failures++; $display("FAIL alt_len[%0d]: got %0d last %0d want %0d", k, r_beats, r_last_beat, PKT + HDR); end
      checks++; if (r_derr !== 0 || r_badpop !== 0) begin failures++; $display("FAIL alt_data[%0d]: got %0d/%0d errors want 0/0", k, r_derr, r_badpop); end
      checks++; if (r_first !== {(exp_ch ? 8'hB1 : 8'hA0), 24'(exp_ch ? exp_base1 : exp_base0)}) begin failures++; $display("FAIL alt_first[%0d]: got %h", k, r_first); end
`ifdef S2MM_ARB_HEADER_EN
      checks++; if (r_hdr !== {exp_ch, 31'(exp_ch ? exp_pkt1 : exp_pkt0)}) begin failures++; $display("FAIL alt_hdr[%0d]: got %h want %h", k, r_hdr, {exp_ch, 31'(exp_ch ? exp_pkt1 : exp_pkt0)}); end
`endif
      if (exp_ch) begin exp_base1 += PKT; exp_pkt1++; end
      else begin exp_base0 += PKT; exp_pkt0++; end
    end
    @(negedge clk);
    checks++; if (pkt_cnt0 !== 32'(exp_pkt0) || pkt_cnt1 !== 32'(exp_pkt1)) begin failures++; $display("FAIL alt_pkt_cnt: got %0d/%0d want %0d/%0d", pkt_cnt0, pkt_cnt1, exp_pkt0, exp_pkt1); end
  endtask

  task automatic test_random_ready();
    collect(1, -1, -1);
    cnt0 = 12'd1023;
    checks++; if (r_vdrop !== 0) begin failures++; $display("FAIL rnd_tvalid_drop: got %0d want 0", r_vdrop); end
    checks++; if (r_badpop !== 0 || r_pops !== PKT) begin failures++; $display("FAIL rnd_pops: got %0d bad %0d pops want 0 bad %0d pops", r_badpop, r_pops, PKT); end
    checks++; if (r_derr !== 0 || r_ch !== 1'b0) begin failures++; $display("FAIL rnd_data: got %0d errors ch%0d want 0 ch0", r_derr, r_ch); end
    checks++; if (r_lasts !== 1 || r_last_beat !== PKT + HDR - 1) begin failures++; $display("FAIL rnd_tlast: got %0d at %0d want 1 at %0d", r_lasts, r_last_beat, PKT + HDR - 1); end
    exp_base0 += PKT; exp_pkt0++;
  endtask

  task automatic test_threshold();
    int bad = 0;
    tready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.M_AXIS_TVALID !== 1'b0 || bus.FIFO0_RD_EN !== 1'b0 || bus.FIFO1_RD_EN !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL thr_no_grant: got %0d active cycles want 0", bad); end
    cnt0 = 12'd1024;
    collect(0, -1, -1);
    cnt0 = '0;
    checks++; if (r_wait !== 0 || r_ch !== 1'b0) begin failures++; $display("FAIL thr_grant: got wait %0d ch%0d want 0 ch0", r_wait, r_ch); end
    checks++; if (r_beats !== PKT + HDR || r_derr !== 0) begin failures++; $display("FAIL thr_pkt: got %0d beats %0d errors want %0d/0", r_beats, r_derr, PKT + HDR); end
    exp_base0 += PKT; exp_pkt0++;
  endtask

  task automatic test_enable_drop();
    int bad = 0;
    @(negedge clk);
    cnt0 = 12'd1024;
    collect(0, 500, -1);
    checks++; if (r_beats !== PKT + HDR || r_lasts !== 1 || r_last_beat !== PKT + HDR - 1) begin failures++; $display("FAIL drop_complete: got %0d beats last %0d want %0d", r_beats, r_last_beat, PKT + HDR); end
    checks++; if (r_derr !== 0 || r_vdrop !== 0) begin failures++; $display("FAIL drop_data: got %0d/%0d errors want 0/0", r_derr, r_vdrop); end
    exp_base0 += PKT; exp_pkt0++;
    repeat (6) begin
      @(negedge clk);
      if (bus.M_AXIS_TVALID !== 1'b0 || bus.FIFO0_RD_EN !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL drop_idle: got %0d active cycles want 0", bad); end
    checks++; if (pkt_cnt0 !== 32'(exp_pkt0)) begin failures++; $display("FAIL drop_pkt_cnt: got %0d want %0d", pkt_cnt0, exp_pkt0); end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    collect(0, -1, 300);
    checks++; if (r_beats !== 301 || r_wait !== 1) begin failures++; $display("FAIL rstmid_pre: got %0d beats wait %0d want 301/1", r_beats, r_wait); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.M_AXIS_TVALID !== 1'b0 || bus.M_AXIS_TLAST !== 1'b0 || bus.FIFO0_RD_EN !== 1'b0) begin failures++; $display("FAIL rstmid_outputs: got v%b l%b r%b want 000", bus.M_AXIS_TVALID, bus.M_AXIS_TLAST, bus.FIFO0_RD_EN); end
    checks++; if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0 || ch_id !== 1'b0) begin failures++; $display("FAIL rstmid_counters: got %0d/%0d ch%0d want 0/0 ch0", pkt_cnt0, pkt_cnt1, ch_id); end
    exp_base0 += 300 - HDR; exp_pkt0 = 0; exp_pkt1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt1 = 12'd1024;
    collect(0, -1, -1);
    cnt0 = '0; cnt1 = '0;
    checks++; if (r_ch !== 1'b0 || r_wait !== 1) begin failures++; $display("FAIL rstmid_fresh: got ch%0d wait %0d want ch0 wait 1", r_ch, r_wait); end
    checks++; if (r_beats !== PKT + HDR || r_derr !== 0 || r_badpop !== 0) begin failures++; $display("FAIL rstmid_pkt: got %0d beats %0d/%0d errors want %0d", r_beats, r_derr, r_badpop, PKT + HDR); end
    checks++; if (r_first !== {8'hA0, 24'(exp_base0)}) begin failures++; $display("FAIL rstmid_first: got %h want %h", r_first, {8'hA0, 24'(exp_base0)}); end
    exp_base0 += PKT; exp_pkt0++;
    @(negedge clk);
    checks++; if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd0) begin failures++; $display("FAIL rstmid_pkt_cnt: got %0d/%0d want 1/0", pkt_cnt0, pkt_cnt1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_random_ready();
    test_threshold();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
